// File: rtl/clock_enable_gen.sv
// Fractional clock-enable generator: NUM_CLOCKS phase accumulators on one reference clock,
// with a settle/lock status and a one-request-at-a-time runtime reprogramming port.
module clock_enable_gen #(
  parameter int unsigned NUM_CLOCKS = 2,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LOCK_DELAY = 1024,
  parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INIT_INC = {NUM_CLOCKS{32'h4000_0000}},
  parameter bit GATE_UNLOCKED = 1'b1,
  localparam int unsigned SelW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SelW-1:0]       cfg_sel,
  input  logic [ACC_WIDTH-1:0]  cfg_inc,
  input  logic [ACC_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] outce,
  output logic [NUM_CLOCKS-1:0] outlvl,
  output logic                  locked
);

  localparam int unsigned CntW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_DELAY - 1);
  localparam logic [SelW:0] NumCh = NUM_CLOCKS[SelW:0];

  typedef enum logic [1:0] {StSettle, StLocked, StUpdate} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic [SelW-1:0]        sh_sel_q, sh_sel_d;
  logic [ACC_WIDTH-1:0]   sh_inc_q, sh_inc_d;
  logic [ACC_WIDTH-1:0]   sh_phase_q, sh_phase_d;
  logic                   accept, sel_ok;

  logic [ACC_WIDTH-1:0]   acc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]   inc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]   inc_d [NUM_CLOCKS];
  logic [ACC_WIDTH:0]     sum   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]  ce_q, ce_d, lvl_q, lvl_d;

  // Control FSM. Out-of-range selectors complete the handshake but leave the state alone.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_sel_d   = sh_sel_q;
    sh_inc_d   = sh_inc_q;
    sh_phase_d = sh_phase_q;
    accept     = cfg_valid && ready_q;
    sel_ok     = ({1'b0, cfg_sel} < NumCh);

    unique case (state_q)
      StSettle: begin
        if (accept && sel_ok) begin
          state_d = StUpdate;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StLocked;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLocked: begin
        if (accept && sel_ok) state_d = StUpdate;
      end
      StUpdate: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
    endcase

    if (accept && sel_ok) begin
      sh_sel_d   = cfg_sel;
      sh_inc_d   = cfg_inc;
      sh_phase_d = cfg_phase;
    end

    // Registered so that ready is low throughout reset and during the UPDATE cycle.
    ready_d = (state_d != StUpdate);
  end

  // Phase accumulators; the selected channel is overwritten instead of advanced in UPDATE.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i] = sum[i][ACC_WIDTH-1:0];
      inc_d[i] = inc_q[i];
      ce_d[i]  = sum[i][ACC_WIDTH];
      lvl_d[i] = sum[i][ACC_WIDTH-1];
      if (state_q == StUpdate && sh_sel_q == SelW'(i)) begin
        acc_d[i] = sh_phase_q;
        inc_d[i] = sh_inc_q;
        ce_d[i]  = 1'b0;
        lvl_d[i] = sh_phase_q[ACC_WIDTH-1];
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSettle;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      sh_sel_q   <= '0;
      sh_inc_q   <= '0;
      sh_phase_q <= '0;
      ce_q       <= '0;
      lvl_q      <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INIT_INC[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      sh_sel_q   <= sh_sel_d;
      sh_inc_q   <= sh_inc_d;
      sh_phase_q <= sh_phase_d;
      ce_q       <= ce_d;
      lvl_q      <= lvl_d;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign locked    = (state_q == StLocked);
  assign cfg_ready = ready_q;
  assign outce     = (GATE_UNLOCKED && !locked) ? '0 : ce_q;
  assign outlvl    = (GATE_UNLOCKED && !locked) ? '0 : lvl_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised bench for clock_enable_gen against a cycle-level arithmetic reference model.
module tb_clock_enable_gen;

  localparam int unsigned NCh = 3;
  localparam int unsigned W = 8;
  localparam int unsigned LockDelay = 16;
  localparam int Mod = 1 << W;
  localparam int Half = 1 << (W - 1);

  logic           refclk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_sel;
  logic [W-1:0]   cfg_inc;
  logic [W-1:0]   cfg_phase;
  logic [NCh-1:0] outce;
  logic [NCh-1:0] outlvl;
  logic           locked;

  clock_enable_gen #(
    .NUM_CLOCKS   (NCh),
    .ACC_WIDTH    (W),
    .LOCK_DELAY   (LockDelay),
    .INIT_INC     ({8'h33, 8'h80, 8'h40}),
    .GATE_UNLOCKED(1'b1)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .outce    (outce),
    .outlvl   (outlvl),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integer arithmetic and a "cycles left to lock" countdown.
  int init_inc [NCh] = '{8'h40, 8'h80, 8'h33};
  int m_acc [NCh];
  int m_inc [NCh];
  bit m_ce  [NCh];
  bit m_lvl [NCh];
  bit m_locked, m_ready, m_pend, m_accepted;
  int m_left, m_sel, m_new_inc, m_new_phase;
  int ce_cnt [NCh];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCh; i++) begin
      m_acc[i] = 0;
      m_inc[i] = init_inc[i];
      m_ce[i]  = 1'b0;
      m_lvl[i] = 1'b0;
    end
    m_locked   = 1'b0;
    m_ready    = 1'b0;
    m_pend     = 1'b0;
    m_accepted = 1'b0;
    m_left     = LockDelay;
  endfunction

  function automatic void model_step();
    int s;
    bit acc;
    acc = cfg_valid && m_ready;
    m_accepted = acc;
    for (int i = 0; i < NCh; i++) begin
      if (m_pend && i == m_sel) begin
        m_acc[i] = m_new_phase;
        m_inc[i] = m_new_inc;
        m_ce[i]  = 1'b0;
        m_lvl[i] = (m_new_phase >= Half);
      end else begin
        s = m_acc[i] + m_inc[i];
        m_ce[i]  = (s >= Mod);
        m_acc[i] = s % Mod;
        m_lvl[i] = (m_acc[i] >= Half);
      end
    end
    if (m_pend) begin
      m_pend   = 1'b0;
      m_locked = 1'b0;
      m_left   = LockDelay;
      m_ready  = 1'b1;
    end else if (acc && int'(cfg_sel) < NCh) begin
      m_pend      = 1'b1;
      m_sel       = int'(cfg_sel);
      m_new_inc   = int'(cfg_inc);
      m_new_phase = int'(cfg_phase);
      m_locked    = 1'b0;
      m_ready     = 1'b0;
    end else begin
      m_ready = 1'b1;
      if (!m_locked) begin
        m_left--;
        if (m_left == 0) m_locked = 1'b1;
      end
    end
  endfunction

  task automatic check_outs();
    logic [NCh-1:0] e_ce, e_lvl;
    for (int i = 0; i < NCh; i++) begin
      e_ce[i]  = m_locked & m_ce[i];
      e_lvl[i] = m_locked & m_lvl[i];
    end
    check("outce", 32'(outce), 32'(e_ce));
    check("outlvl", 32'(outlvl), 32'(e_lvl));
    check("locked", 32'(locked), 32'(m_locked));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic step();
    @(posedge refclk);
    if (rst_n) model_step();
    @(negedge refclk);
    check_outs();
    for (int i = 0; i < NCh; i++) ce_cnt[i] += int'(outce[i]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NCh; i++) ce_cnt[i] = 0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    check_outs();
  endtask

  task automatic request(input int sel, input int inc, input int phase);
    bit done;
    done      = 1'b0;
    cfg_valid = 1'b1;
    cfg_sel   = 2'(sel);
    cfg_inc   = W'(inc);
    cfg_phase = W'(phase);
    for (int k = 0; k < 4 && !done; k++) begin
      step();
      done = m_accepted;
    end
    cfg_valid = 1'b0;
    check("req_accept", 32'(done), 32'd1);
  endtask

  function automatic int rand_inc();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return Half;
      3:       return Mod - 1;
      default: return int'($urandom_range(0, Mod - 1));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = '0;
    cfg_inc   = '0;
    cfg_phase = '0;
    model_reset();
    clear_counts();
    @(negedge refclk);
    reset_pulse();

    // Lock after exactly LockDelay edges, then nominal periods 4 and 2.
    clear_counts();
    run(LockDelay - 1);
    check("lock_early", 32'(locked), 32'd0);
    check("gated_ce", 32'(ce_cnt[0] + ce_cnt[1]), 32'd0);
    run(1);
    check("lock_edge", 32'(locked), 32'd1);
    clear_counts();
    run(16);
    check("ch0_period4", 32'(ce_cnt[0]), 32'd4);
    check("ch1_period2", 32'(ce_cnt[1]), 32'd8);

    // Reprogram ch0 while locked.
    request(0, 'h20, 'hF0);
    check("upd_ready", 32'(cfg_ready), 32'd0);
    check("upd_unlock", 32'(locked), 32'd0);
    run(LockDelay);
    check("relock_early", 32'(locked), 32'd0);
    run(1);
    check("relock", 32'(locked), 32'd1);
    clear_counts();
    run(32);
    check("ch0_period8", 32'(ce_cnt[0]), 32'd4);
    check("ch1_undisturbed", 32'(ce_cnt[1]), 32'd16);

    // Frozen channel, then near-full-rate channel.
    request(1, 0, 0);
    clear_counts();
    run(512);
    check("ch1_frozen", 32'(ce_cnt[1]), 32'd0);
    request(1, 'hFF, int'($urandom_range(0, Mod - 1)));
    run(LockDelay + 1);
    clear_counts();
    run(256);
    check("ch1_ff_255", 32'(ce_cnt[1]), 32'd255);

    // Out-of-range selector is swallowed.
    request(3, rand_inc(), int'($urandom_range(0, Mod - 1)));
    check("oor_locked", 32'(locked), 32'd1);
    check("oor_ready", 32'(cfg_ready), 32'd1);
    clear_counts();
    run(32);
    check("oor_ch0", 32'(ce_cnt[0]), 32'd4);

    // Second request during SETTLE restarts the settle count.
    request(2, 'h10, 0);
    run(6);
    request(2, 'h08, 'h80);
    run(LockDelay);
    check("settle2_early", 32'(locked), 32'd0);
    run(1);
    check("settle2_lock", 32'(locked), 32'd1);

    // Reset during a pending update abandons it.
    cfg_valid = 1'b1;
    cfg_sel   = 2'd0;
    cfg_inc   = 8'h01;
    cfg_phase = 8'h7F;
    step();
    cfg_valid = 1'b0;
    reset_pulse();
    run(LockDelay - 1);
    check("rst_lock_early", 32'(locked), 32'd0);
    run(1);
    check("rst_lock", 32'(locked), 32'd1);
    clear_counts();
    run(16);
    check("rst_ch0_init", 32'(ce_cnt[0]), 32'd4);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else if (!cfg_valid && $urandom_range(0, 59) == 0) begin
        cfg_valid = 1'b1;
        cfg_sel   = 2'($urandom_range(0, 3));
        cfg_inc   = W'(rand_inc());
        cfg_phase = W'($urandom_range(0, Mod - 1));
      end
      step();
      if (m_accepted) cfg_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
